// File: rtl/adder22_acc_seq.sv
// Neuron MAC accumulator sequencer: drives an external 22b adder to sum N_TERMS products plus bias.
// Build option: define SATURATE_EN to clamp the accumulator on signed overflow instead of wrapping.
module adder22_acc_seq #(
    parameter int N_TERMS = 784,
    parameter int CNT_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] bias,
    input  logic        in_valid,
    input  logic [19:0] in_data,
    output logic        in_ready,
    output logic [19:0] add_a,
    output logic [21:0] add_b,
    input  logic [21:0] add_sum,
    output logic        out_valid,
    output logic [21:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_BIAS  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [21:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [19:0] bias_reg;
    logic        ovf_reg;

    logic        beat;
    logic        add_fire;
    logic        add_ovf;
    logic        last_beat;
    logic [21:0] sum_q;

    assign beat      = (state_reg == S_ACCUM) && in_valid;
    assign add_fire  = beat || (state_reg == S_BIAS);
    assign last_beat = (cnt_reg == CNT_W'(N_TERMS - 1));

    // Both operands share a sign but the result does not: two's-complement overflow.
    assign add_ovf = (add_a[19] == add_b[21]) && (add_sum[21] != add_b[21]);

`ifdef SATURATE_EN
    assign sum_q = add_ovf ? (add_b[21] ? 22'h200000 : 22'h1FFFFF) : add_sum;
`else
    assign sum_q = add_sum;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start)              state_next = S_ACCUM;
            S_ACCUM: if (beat && last_beat)  state_next = S_BIAS;
            S_BIAS:                          state_next = S_OUT;
            S_OUT:   if (out_ready)          state_next = S_IDLE;
            default:                         state_next = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg  <= '0;
            cnt_reg  <= '0;
            bias_reg <= '0;
            ovf_reg  <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            if (start) begin
                acc_reg  <= '0;
                cnt_reg  <= '0;
                bias_reg <= bias;
                ovf_reg  <= 1'b0;
            end
        end else if (add_fire) begin
            acc_reg <= sum_q;
            if (add_ovf) begin
                ovf_reg <= 1'b1;
            end
            if (beat) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Outputs, decoded from the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        add_a     = '0;
        add_b     = acc_reg;
        busy      = (state_reg != S_IDLE);
        ovf       = ovf_reg;
        case (state_reg)
            S_ACCUM: begin
                in_ready = 1'b1;
                add_a    = in_data;
            end
            S_BIAS: begin
                add_a = bias_reg;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = acc_reg;
            end
            default: begin
                add_a = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_adder22_acc_seq.sv
// Bench for adder22_acc_seq: table-driven neurons on a 4-term instance, overflow on an 8-term instance.
module tb_adder22_acc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, start, start8, in_valid, out_ready;
    logic [19:0] bias, in_data;

    logic        in_ready, out_valid, busy, ovf;
    logic [19:0] add_a;
    logic [21:0] add_b, add_sum, out_data;

    logic        in_ready8, out_valid8, busy8, ovf8;
    logic [19:0] add_a8;
    logic [21:0] add_b8, add_sum8, out_data8;

    // External adders: sign-extend the 20b operand and add
    assign add_sum  = {{2{add_a[19]}}, add_a} + add_b;
    assign add_sum8 = {{2{add_a8[19]}}, add_a8} + add_b8;

    adder22_acc_seq #(.N_TERMS(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    adder22_acc_seq #(.N_TERMS(8), .CNT_W(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
        .add_a(add_a8), .add_b(add_b8), .add_sum(add_sum8),
        .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready),
        .busy(busy8), .ovf(ovf8)
    );

    typedef struct {
        logic [19:0]      b;
        logic [3:0][19:0] p;
        logic [3:0][3:0]  g;
        logic [21:0]      e;
        logic             eo;
    } vec_t;

    vec_t vt[6];
    int total = 0;
    int bad = 0;
    int t_out = 0;
    int t_first = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][19:0] mk(input logic [19:0] a, input logic [19:0] b,
                                            input logic [19:0] c, input logic [19:0] d);
        return {d, c, b, a};
    endfunction

    // One neuron on the 4-term instance; starts in IDLE, ends in IDLE after the output handshake.
    task automatic run_neuron(input logic [19:0] b, input logic [3:0][19:0] p,
                              input logic [3:0][3:0] g, input logic [21:0] e,
                              input logic eo, input string nm);
        start = 1'b1;
        bias  = b;
        step();
        start = 1'b0;
        bias  = 20'h0ABCD;
        chk({nm, ".ready"}, {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < int'(g[k]); j++) begin
                in_valid = 1'b0;
                in_data  = 20'h55555;
                step();
            end
            in_valid = 1'b1;
            in_data  = p[k];
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk({nm, ".bias_ready"}, {31'b0, in_ready}, 32'd0);
        chk({nm, ".bias_valid"}, {31'b0, out_valid}, 32'd0);
        chk({nm, ".bias_add_a"}, {12'b0, add_a}, {12'b0, b});
        step();
        t_out = cyc;
        chk({nm, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({nm, ".data"}, {10'b0, out_data}, {10'b0, e});
        chk({nm, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
        chk({nm, ".busy"}, {31'b0, busy}, 32'd1);
        $display("neuron %s: out_data=%h ovf=%b", nm, out_data, ovf);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, ".idle_busy"}, {31'b0, busy}, 32'd0);
        chk({nm, ".idle_data"}, {10'b0, out_data}, 32'd0);
    endtask

    initial begin
        vt[0] = '{b: 20'd5, p: mk(20'd1, 20'd2, 20'd3, 20'd4), g: '0, e: 22'd15, eo: 1'b0};
        vt[1] = '{b: -20'sd10, p: mk(-20'sd100, 20'd50, -20'sd1, 20'd7),
                  g: {4'd2, 4'd1, 4'd3, 4'd0}, e: -22'sd54, eo: 1'b0};
        vt[2] = '{b: 20'd0, p: '0, g: {4'd1, 4'd0, 4'd1, 4'd0}, e: 22'd0, eo: 1'b0};
        vt[3] = '{b: 20'd3, p: mk(20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF),
                  g: '0, e: 22'h1FFFFF, eo: 1'b0};
`ifdef SATURATE_EN
        vt[4] = '{b: 20'hFFFFF, p: mk(20'h80000, 20'h80000, 20'h80000, 20'h80000),
                  g: '0, e: 22'h200000, eo: 1'b1};
`else
        vt[4] = '{b: 20'hFFFFF, p: mk(20'h80000, 20'h80000, 20'h80000, 20'h80000),
                  g: '0, e: 22'h1FFFFF, eo: 1'b1};
`endif
        vt[5] = '{b: 20'd0, p: mk(20'd1, 20'd1, 20'd1, 20'd1), g: '0, e: 22'd4, eo: 1'b0};

        rst = 1'b1; start = 1'b0; start8 = 1'b0; bias = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.out_data", {10'b0, out_data}, 32'd0);
        chk("rst.ovf", {31'b0, ovf}, 32'd0);
        chk("rst.add_b", {10'b0, add_b}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_neuron(vt[i].b, vt[i].p, vt[i].g, vt[i].e, vt[i].eo, $sformatf("vec%0d", i));
        end

        // Reset mid-neuron after two beats; partial sum must be discarded
        start = 1'b1; bias = 20'd3;
        step();
        start = 1'b0; in_valid = 1'b1; in_data = 20'd9;
        step();
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.busy", {31'b0, busy}, 32'd0);
        chk("midrst.in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.add_b", {10'b0, add_b}, 32'd0);
        chk("midrst.add_a", {12'b0, add_a}, 32'd0);
        $display("midrst: busy=%b in_ready=%b", busy, in_ready);
        run_neuron(vt[5].b, vt[5].p, vt[5].g, vt[5].e, vt[5].eo, "after_rst");

        // Backpressure with a start pulse while the result waits
        start = 1'b1; bias = 20'd7;
        step();
        start = 1'b0; in_valid = 1'b1; in_data = 20'd10;
        for (int k = 0; k < 4; k++) step();
        in_valid = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d.data", c), {10'b0, out_data}, 32'd47);
            chk($sformatf("bp%0d.valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp%0d.busy", c), {31'b0, busy}, 32'd1);
            start = (c == 2);
            step();
        end
        start = 1'b0;
        chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1; start = 1'b1;
        step();
        out_ready = 1'b0; start = 1'b0;
        chk("bp.release_busy", {31'b0, busy}, 32'd0);
        chk("bp.release_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("bp.no_restart", {31'b0, busy}, 32'd0);
        $display("backpressure: held 5 cycles, busy=%b after release", busy);

        // Back-to-back neurons: period must be N_TERMS+3
        run_neuron(20'd100, mk(20'd1, 20'd2, 20'd3, 20'd4), '0, 22'd110, 1'b0, "b2b_a");
        t_first = t_out;
        run_neuron(-20'sd1, mk(20'd8, 20'd8, -20'sd2, 20'd0), '0, 22'd13, 1'b0, "b2b_b");
        chk("b2b.period", t_out - t_first, 32'd7);
        $display("back-to-back: period=%0d", t_out - t_first);

        // Overflow on the 8-term instance: eight max-positive products, bias 0
        start8 = 1'b1; bias = 20'd0;
        step();
        start8 = 1'b0; in_valid = 1'b1; in_data = 20'h7FFFF;
        for (int k = 0; k < 8; k++) step();
        in_valid = 1'b0;
        step();
        chk("ovf8.valid", {31'b0, out_valid8}, 32'd1);
        chk("ovf8.ovf", {31'b0, ovf8}, 32'd1);
`ifdef SATURATE_EN
        chk("ovf8.data", {10'b0, out_data8}, 32'h001FFFFF);
`else
        chk("ovf8.data", {10'b0, out_data8}, 32'h003FFFF8);
`endif
        $display("overflow: out_data=%h ovf=%b", out_data8, ovf8);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ovf8.sticky_idle", {31'b0, ovf8}, 32'd1);
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("ovf8.cleared_on_start", {31'b0, ovf8}, 32'd0);
        chk("ovf8.ready", {31'b0, in_ready8}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
